// File: rtl/led7_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver. Each digit gets one REFRESH_DIV-cycle slot.
// seg/dp/an are registered one cycle behind the scan state. The block is free-running and has no backpressure.
module led7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);
  localparam int CW = $clog2(REFRESH_DIV + 1);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_ph;
  logic [4*NUM_DIGITS-1:0] shadow_dig;
  logic [NUM_DIGITS-1:0]   shadow_dp;

  logic                    slot_end;
  logic                    frame_end;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blink;
  logic                    upper_zero;
  logic                    anode_off;
  logic                    blank;
  logic [6:0]              seg_dec;
  logic [NUM_DIGITS-1:0]   an_nxt;

  assign slot_end  = (cnt == CW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      blink_cnt  <= '0;
      blink_ph   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (slot_end) begin
        cnt <= '0;
        idx <= frame_end ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
      if (frame_end) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_dig <= '0;
      shadow_dp  <= '0;
    end else if (load) begin
      shadow_dig <= digits;
      shadow_dp  <= dp_in;
    end
  end

  // Select the current digit and check whether it and every digit above it are zero.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blink  = 1'b0;
    upper_zero = 1'b1;
    anode_off  = !enable || (cnt < CW'(GUARD));
    an_nxt     = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (k == int'(idx)) begin
        cur_nib   = shadow_dig[4*k +: 4];
        cur_dp    = shadow_dp[k];
        cur_blink = blink_mask[k];
        an_nxt[k] = anode_off;
      end
      if ((k >= int'(idx)) && (shadow_dig[4*k +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    blank = anode_off
         || (lz_blank && upper_zero && (idx != '0))
         || (cur_blink && blink_ph);
  end

  always_comb begin
    seg_dec = 7'h7F;
    case (cur_nib)
      4'h0: seg_dec = 7'h40;
      4'h1: seg_dec = 7'h79;
      4'h2: seg_dec = 7'h24;
      4'h3: seg_dec = 7'h30;
      4'h4: seg_dec = 7'h19;
      4'h5: seg_dec = 7'h12;
      4'h6: seg_dec = 7'h02;
      4'h7: seg_dec = 7'h78;
      4'h8: seg_dec = 7'h00;
      4'h9: seg_dec = 7'h10;
      4'hA: seg_dec = 7'h08;
      4'hB: seg_dec = 7'h03;
      4'hC: seg_dec = 7'h46;
      4'hD: seg_dec = 7'h21;
      4'hE: seg_dec = 7'h06;
      4'hF: seg_dec = 7'h0E;
      default: seg_dec = 7'h7F;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= '1;
    end else begin
      seg <= blank ? 7'h7F : seg_dec;
      dp  <= blank | ~cur_dp;
      an  <= an_nxt;
    end
  end

endmodule

// File: doc/led7_scan_driver.md
Name: led7_scan_driver

Overview:
- Parametrised, time-multiplexed driver for a bank of NUM_DIGITS common-anode seven-segment digits.
- Latches a packed hex word on a load strobe and scans one digit per refresh slot.
- Decodes each nibble to an active-low segment pattern, with anode guard time, leading-zero suppression and per-digit blinking.
- Sits between register and status logic and the board display pins, replacing one static decoder per digit.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..16.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be greater than GUARD.
- GUARD, 2: cycles at the start of each slot during which every anode is off (anti-ghosting).
- BLINK_FRAMES, 64: full frames per blink half-period; legal minimum 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  1 = display on; 0 = all outputs inactive while scanning continues.
- load  input  1  one-cycle strobe that captures digits and dp_in.
- digits  input  4*NUM_DIGITS  packed nibbles; nibble i (bits 4i+3:4i) is digit i, and digit 0 is least significant.
- dp_in  input  NUM_DIGITS  decimal point per digit; 1 = lit.
- lz_blank  input  1  1 = suppress leading zeros.
- blink_mask  input  NUM_DIGITS  1 = the digit blinks.
- seg  output  7  segments {g,f,e,d,c,b,a}; active low.
- dp  output  1  decimal point; active low.
- an  output  NUM_DIGITS  digit anode enables; active low, one-hot-low when on.
- frame_done  output  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset (rst=1 at a clock edge):
  - slot counter cnt=0, digit index idx=0, blink phase=0, blink frame counter=0.
  - Shadow digits and dp registers cleared to 0.
  - Outputs: seg=7'h7F, dp=1, an=all 1s, frame_done=0.
  - Reset mid-scan aborts the current slot; the first slot after reset is digit 0.
- Scan counters:
  - cnt counts 0..REFRESH_DIV-1.
  - When cnt=REFRESH_DIV-1: cnt returns to 0 and idx increments.
  - idx wraps from NUM_DIGITS-1 to 0. On that wrap, frame_done pulses high for exactly one cycle (registered, coincident with the idx=0 update).
  - Blink frame counter increments on each frame_done. On reaching BLINK_FRAMES-1 it clears and the blink phase toggles.
- Load:
  - load=1 captures digits and dp_in into the shadow registers on that edge.
  - The new values drive decode from the next cycle, even mid-frame.
  - No other input is registered; lz_blank and blink_mask act combinationally on decode.
- Decode of shadow nibble n, active-low hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Digit blank condition for the current digit i (any one is sufficient):
  - enable=0, or
  - cnt<GUARD, or
  - lz_blank=1 and every shadow nibble from NUM_DIGITS-1 down to i is 0, and i≠0 (digit 0 is never suppressed), or
  - blink_mask[i]=1 and blink phase=1.
- Output values:
  - When blanked: seg=7'h7F, dp=1 (segments off).
  - When not blanked: seg=decode(nibble i), dp=~dp_shadow[i].
  - an[i]=0 only when enable=1 and cnt≥GUARD. Guard and enable=0 turn the anode off; lz and blink blanking keep the anode on with segments off.
  - All other an bits are 1.
- Latency:
  - seg, dp and an are registered. The values at cycle t+1 reflect cnt, idx and the shadow registers at cycle t.
  - Anode-on time per slot is exactly REFRESH_DIV-GUARD cycles.
- Boundary conditions:
  - With NUM_DIGITS=1, idx stays 0 and frame_done pulses every REFRESH_DIV cycles.
  - load coincident with a slot change: the new digit is decoded with the new data.
  - enable toggling does not reset the counters or the blink phase.

Test Plan (bench parameters: NUM_DIGITS=4, REFRESH_DIV=8, GUARD=2, BLINK_FRAMES=2):
1. Reset then scan: rst for 3 cycles, then load digits=16'h12AF, dp_in=0, enable=1.
   - an cycles through 1110, 1101, 1011, 0111, each low for 6 of 8 cycles.
   - seg is 0E, 08, 24, 79 for digits 0..3.
   - frame_done pulses every 32 cycles.
2. Guard: check every slot boundary.
   - an=1111 and seg=7F for 2 cycles after each idx change (allowing for the 1-cycle output lag).
3. Leading zeros: load 16'h0005, lz_blank=1.
   - Digits 3..1 show seg=7F with their anode active; digit 0 shows 12.
   - Load 16'h0000: only digit 0 lit, seg=40.
   - With lz_blank=0: all four digits show 40.
4. Blink and dp: blink_mask=4'b0010, dp_in=4'b0100, digits=16'h8888.
   - Digit 1 shows 00 for 2 frames, then 7F for 2 frames, repeating.
   - dp=0 only during digit 2's slot.
5. Enable and reset mid-frame:
   - enable=0 for 20 cycles: an=1111 and seg=7F throughout; frame_done timing unchanged.
   - rst asserted during slot 2: next cycle all outputs at their reset values; scanning restarts at digit 0 with shadow cleared, so seg=40.
